// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / interrupt unit:
// CSR addresses, mstatus bit positions, operation and sleep-state enums.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int LOCAL_IRQ_BASE = 16;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_WR   = 2'b01,
        CSR_SET  = 2'b10,
        CSR_CLR  = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } sleep_state_e;

    // Read-modify-write result of a CSR instruction on the old value.
    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_WR:  res = wdata;
            CSR_SET: res = old_val | wdata;
            CSR_CLR: res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Fixed-priority encoder: the lowest pending index wins; id is 0 when idle.
module csr_irq_arb
    import csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] pend_i,
    output logic               valid_o,
    output logic [3:0]         id_o
);

    // Scan from the top down so the lowest set index is the last one kept.
    always_comb begin
        valid_o = |pend_i;
        id_o    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            id_o = pend_i[i] ? 4'(i) : id_o;
        end
    end

endmodule

// File: rtl/csr_irq_vec.sv
// Machine-mode CSR file with NUM_IRQ local interrupts, fixed priority,
// direct/vectored mtvec, 64-bit style counters and a WFI sleep FSM.
module csr_irq_vec
    import csr_pkg::*;
#(
    parameter int          NUM_IRQ   = 4,
    parameter int          CNT_BITS  = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_en_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [1:0]         csr_op_i,
    input  logic [31:0]        csr_wdata_i,
    output logic [31:0]        csr_rdata_o,
    input  logic [31:0]        pc_i,
    input  logic               retire_i,
    input  logic               wfi_i,
    input  logic               mret_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [31:0]        trap_pc_o,
    output logic [31:0]        ret_pc_o,
    output logic               int_o,
    output logic [3:0]         irq_id_o,
    output logic               mret_o,
    output logic               stall_o
);

    localparam int                  HI_W    = CNT_BITS - 32;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    sleep_state_e        state_q, state_d;
    logic                stall_q;
    logic [NUM_IRQ-1:0]  mip_q, mie_q, mie_d;
    logic                mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [1:0]          mst_mpp_q, mst_mpp_d;
    logic [31:0]         mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0]         mepc_q, mepc_d, mcause_q, mcause_d, wfi_pc_q, wfi_pc_d;
    logic [CNT_BITS-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [NUM_IRQ-1:0]  pend_s;
    logic                pend_any_s, take_s, mret_s, wr_en_s, run_s;
    logic [3:0]          irq_id_s;
    logic [31:0]         irq_code_s, tvec_base_s, old_s, new_s;
    csr_op_e             op_s;

    assign pend_s = mip_q & mie_q;

    csr_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
        .pend_i  (pend_s),
        .valid_o (pend_any_s),
        .id_o    (irq_id_s)
    );

    // Instructions are only honoured while running; in SLEEP csr_en_i is ignored.
    assign run_s      = (state_q == ST_RUN);
    assign op_s       = csr_op_e'(csr_op_i);
    assign take_s     = mst_mie_q & pend_any_s & (~run_s | csr_en_i);
    assign mret_s     = csr_en_i & mret_i & run_s & ~take_s;
    assign wr_en_s    = csr_en_i & run_s & (op_s != CSR_NONE) & ~take_s & ~mret_i
                      & ((op_s == CSR_WR) | (csr_wdata_i != 32'd0));
    assign irq_code_s = 32'(LOCAL_IRQ_BASE) + {28'd0, irq_id_s};
    assign tvec_base_s = {mtvec_q[31:2], 2'b00};
    assign new_s      = csr_apply_op(op_s, old_s, csr_wdata_i);

    assign csr_rdata_o = old_s;
    assign trap_pc_o   = mtvec_q[0] ? (tvec_base_s + (irq_code_s << 2)) : tvec_base_s;
    assign ret_pc_o    = mepc_q;
    assign int_o       = take_s;
    assign irq_id_o    = irq_id_s;
    assign mret_o      = csr_en_i & mret_i;
    assign stall_o     = stall_q;

    // Old value of the addressed CSR; unmapped addresses read as zero.
    always_comb begin
        old_s = 32'd0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                old_s[MSTATUS_MIE]                   = mst_mie_q;
                old_s[MSTATUS_MPIE]                  = mst_mpie_q;
                old_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mst_mpp_q;
            end
            CSR_MIE:       old_s = 32'(mie_q) << LOCAL_IRQ_BASE;
            CSR_MIP:       old_s = 32'(mip_q) << LOCAL_IRQ_BASE;
            CSR_MTVEC:     old_s = mtvec_q;
            CSR_MSCRATCH:  old_s = mscratch_q;
            CSR_MEPC:      old_s = mepc_q;
            CSR_MCAUSE:    old_s = mcause_q;
            CSR_MCYCLE:    old_s = mcycle_q[31:0];
            CSR_MINSTRET:  old_s = minstret_q[31:0];
            CSR_MCYCLEH:   old_s = 32'(mcycle_q[CNT_BITS-1:32]);
            CSR_MINSTRETH: old_s = 32'(minstret_q[CNT_BITS-1:32]);
            default:       old_s = 32'd0;
        endcase
    end

    // Trap entry beats MRET, which beats an ordinary CSR write.
    always_comb begin
        mie_d      = mie_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mst_mpp_d  = mst_mpp_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (take_s) begin
            mepc_d     = (run_s ? pc_i : (wfi_pc_q + 32'd4)) & 32'hFFFF_FFFC;
            mcause_d   = 32'h8000_0000 | irq_code_s;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mst_mpp_d  = 2'b11;
        end else if (mret_s) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            mst_mpp_d  = 2'b11;
        end else if (wr_en_s) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mst_mie_d  = new_s[MSTATUS_MIE];
                    mst_mpie_d = new_s[MSTATUS_MPIE];
                    mst_mpp_d  = new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
                CSR_MIE:      mie_d      = new_s[LOCAL_IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC:    mtvec_d    = new_s & 32'hFFFF_FFFD;
                CSR_MSCRATCH: mscratch_d = new_s;
                CSR_MEPC:     mepc_d     = new_s & 32'hFFFF_FFFC;
                CSR_MCAUSE:   mcause_d   = new_s;
                default:      mscratch_d = mscratch_q;
            endcase
        end else begin
            mscratch_d = mscratch_q;
        end
    end

    // Counters free-run; a write to either half replaces it and skips the increment.
    always_comb begin
        mcycle_d   = mcycle_q + CNT_ONE;
        minstret_d = retire_i ? (minstret_q + CNT_ONE) : minstret_q;
        if (wr_en_s) begin
            case (csr_addr_i)
                CSR_MCYCLE: begin
                    mcycle_d       = mcycle_q;
                    mcycle_d[31:0] = new_s;
                end
                CSR_MCYCLEH: begin
                    mcycle_d                = mcycle_q;
                    mcycle_d[CNT_BITS-1:32] = new_s[HI_W-1:0];
                end
                CSR_MINSTRET: begin
                    minstret_d       = minstret_q;
                    minstret_d[31:0] = new_s;
                end
                CSR_MINSTRETH: begin
                    minstret_d                = minstret_q;
                    minstret_d[CNT_BITS-1:32] = new_s[HI_W-1:0];
                end
                default: mcycle_d = mcycle_q + CNT_ONE;
            endcase
        end else begin
            mcycle_d = mcycle_q + CNT_ONE;
        end
    end

    // WFI sleeps only when nothing is pending; any pending source wakes it.
    always_comb begin
        state_d  = state_q;
        wfi_pc_d = wfi_pc_q;
        case (state_q)
            ST_RUN: begin
                if (csr_en_i & wfi_i & ~pend_any_s) begin
                    state_d  = ST_SLEEP;
                    wfi_pc_d = pc_i;
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_SLEEP: begin
                if (pend_any_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, CSR and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            stall_q    <= 1'b0;
            wfi_pc_q   <= 32'd0;
            mip_q      <= '0;
            mie_q      <= '0;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mst_mpp_q  <= 2'b00;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= (state_d == ST_SLEEP);
            wfi_pc_q   <= wfi_pc_d;
            mip_q      <= irq_i;
            mie_q      <= mie_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mst_mpp_q  <= mst_mpp_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_irq_vec.sv
// Directed and randomized bench for csr_irq_vec with a behavioural CSR model.
module tb_csr_irq_vec;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en_i, retire_i, wfi_i, mret_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i, pc_i;
    logic [3:0]  irq_i;
    logic [31:0] csr_rdata_o, trap_pc_o, ret_pc_o;
    logic        int_o, mret_o, stall_o;
    logic [3:0]  irq_id_o;

    int checks = 0, failures = 0, edges = 0, retired = 0;

    csr_irq_vec #(.NUM_IRQ(4), .CNT_BITS(64), .MTVEC_RST(32'h0001_0000)) dut (
        .clk(clk), .rst(rst), .csr_en_i(csr_en_i), .csr_addr_i(csr_addr_i),
        .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .pc_i(pc_i), .retire_i(retire_i), .wfi_i(wfi_i), .mret_i(mret_i),
        .irq_i(irq_i), .trap_pc_o(trap_pc_o), .ret_pc_o(ret_pc_o), .int_o(int_o),
        .irq_id_o(irq_id_o), .mret_o(mret_o), .stall_o(stall_o)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        if (retire_i) retired++;
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic idle();
        csr_en_i = 1'b0; csr_addr_i = 12'h000; csr_op_i = 2'b00; csr_wdata_i = 32'd0;
        retire_i = 1'b0; wfi_i = 1'b0; mret_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_addr_i = a;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_en_i = 1'b1; csr_addr_i = a; csr_op_i = op; csr_wdata_i = d;
        cyc();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); irq_i = 4'd0; pc_i = 32'd0;
        cyc(); cyc();
        rst = 1'b0; edges = 0; retired = 0;
    endtask

    // model storage for the randomized phase
    logic [11:0] ra [7];
    logic [31:0] mk [7];
    logic [31:0] mv [7];
    logic [31:0] wd, nv;
    logic [3:0]  pat;
    logic [1:0]  op;
    int          j, exp_id, found, wake_w, saw_int;

    initial begin
        ra = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MIP};
        mk = '{32'h0000_1888, 32'h000F_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000};

        // ---- reset state
        do_reset();
        #1;
        chk("rst_rdata_unmapped", csr_rdata_o, 32'd0);
        chk("rst_stall", stall_o, 32'd0);
        chk("rst_int", int_o, 32'd0);
        chk("rst_irq_id", irq_id_o, 32'd0);
        chk("rst_mret", mret_o, 32'd0);
        chk("rst_trap_pc", trap_pc_o, 32'h0001_0000);
        chk("rst_ret_pc", ret_pc_o, 32'd0);
        rd(CSR_MTVEC, 32'h0001_0000, "rst_mtvec");
        rd(CSR_MSTATUS, 32'd0, "rst_mstatus");
        rd(CSR_MIE, 32'd0, "rst_mie");
        rd(CSR_MIP, 32'd0, "rst_mip");
        rd(CSR_MCAUSE, 32'd0, "rst_mcause");
        rd(CSR_MSCRATCH, 32'd0, "rst_mscratch");

        // ---- set / clear with zero data
        csr_wr(CSR_MSTATUS, 2'b01, 32'd0);
        csr_wr(CSR_MSTATUS, 2'b10, 32'h8);
        rd(CSR_MSTATUS, 32'h8, "set_mstatus");
        csr_wr(CSR_MSTATUS, 2'b11, 32'd0);
        rd(CSR_MSTATUS, 32'h8, "clr0_mstatus");
        csr_wr(CSR_MIP, 2'b01, 32'hFFFF_FFFF);
        rd(CSR_MIP, 32'd0, "mip_readonly");

        // ---- vectored priority
        csr_wr(CSR_MTVEC, 2'b01, 32'h0002_0003);
        rd(CSR_MTVEC, 32'h0002_0001, "mtvec_bit1");
        csr_wr(CSR_MIE, 2'b01, 32'hFFFF_FFFF);
        rd(CSR_MIE, 32'h000F_0000, "mie_mask");
        irq_i = 4'b0101;
        cyc();
        #1;
        chk("no_take_without_en", int_o, 32'd0);
        rd(CSR_MIP, 32'h0005_0000, "mip_sample");
        csr_en_i = 1'b1; csr_addr_i = CSR_MSCRATCH; pc_i = 32'h200;
        #1;
        chk("vec_int", int_o, 32'd1);
        chk("vec_id", irq_id_o, 32'd0);
        chk("vec_trap_pc", trap_pc_o, 32'h0002_0040);
        cyc(); idle(); irq_i = 4'd0;
        rd(CSR_MCAUSE, 32'h8000_0010, "vec_mcause");
        rd(CSR_MSTATUS, 32'h0000_1880, "vec_mstatus");
        rd(CSR_MEPC, 32'h200, "vec_mepc");
        cyc();

        // ---- randomized source patterns against a lowest-index rule
        for (int n = 0; n < 6; n++) begin
            pat = 4'($urandom_range(15, 1));
            irq_i = pat;
            cyc();
            csr_en_i = 1'b1; mret_i = 1'b1;
            #1;
            chk("rp_mret_o", mret_o, 32'd1);
            chk("rp_no_take_mie0", int_o, 32'd0);
            cyc(); idle();
            exp_id = 0;
            while (pat[exp_id] == 1'b0) exp_id++;
            csr_en_i = 1'b1; pc_i = 32'h400 + 32'(n * 4);
            #1;
            chk("rp_int", int_o, 32'd1);
            chk("rp_id", irq_id_o, 32'(exp_id));
            chk("rp_trap_pc", trap_pc_o, 32'h0002_0000 + 32'(4 * (16 + exp_id)));
            cyc(); idle(); irq_i = 4'd0;
            rd(CSR_MCAUSE, 32'h8000_0000 + 32'(16 + exp_id), "rp_mcause");
            rd(CSR_MEPC, 32'h400 + 32'(n * 4), "rp_mepc");
            cyc();
        end

        // ---- WFI sleep and interrupt wake
        csr_wr(CSR_MSTATUS, 2'b10, 32'h8);
        csr_wr(CSR_MIE, 2'b01, 32'h0004_0000);
        csr_en_i = 1'b1; wfi_i = 1'b1; pc_i = 32'h100;
        #1;
        chk("wfi_no_int", int_o, 32'd0);
        cyc(); idle();
        chk("wfi_stall", stall_o, 32'd1);
        cyc();
        chk("wfi_stall_hold", stall_o, 32'd1);
        irq_i = 4'b0100;
        found = 0; wake_w = -1;
        for (int w = 0; w < 6 && found == 0; w++) begin
            cyc();
            if (int_o) begin found = 1; wake_w = w; end
        end
        chk("wfi_take_seen", 32'(found), 32'd1);
        chk("wfi_take_latency", 32'(wake_w), 32'd0);
        chk("wfi_id", irq_id_o, 32'd2);
        irq_i = 4'd0;
        cyc();
        chk("wfi_stall_drop", stall_o, 32'd0);
        chk("wfi_mepc", ret_pc_o, 32'h104);
        rd(CSR_MCAUSE, 32'h8000_0012, "wfi_mcause");
        cyc();
        csr_en_i = 1'b1; mret_i = 1'b1;
        #1;
        chk("mret_o", mret_o, 32'd1);
        chk("mret_ret_pc", ret_pc_o, 32'h104);
        cyc(); idle();
        rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");

        // ---- counter low-half write and carry
        csr_wr(CSR_MCYCLE, 2'b01, 32'hFFFF_FFFF);
        rd(CSR_MCYCLE, 32'hFFFF_FFFF, "cnt_lo_written");
        rd(CSR_MCYCLEH, 32'd0, "cnt_hi_before");
        cyc();
        rd(CSR_MCYCLEH, 32'd1, "cnt_hi_carry");
        rd(CSR_MCYCLE, 32'd0, "cnt_lo_wrap");

        // ---- wake with MIE=0: no trap, CSR writes ignored while asleep
        csr_wr(CSR_MSTATUS, 2'b11, 32'h8);
        csr_wr(CSR_MIE, 2'b01, 32'h0001_0000);
        csr_en_i = 1'b1; wfi_i = 1'b1; pc_i = 32'h180;
        cyc(); idle();
        chk("nomie_stall", stall_o, 32'd1);
        csr_wr(CSR_MSCRATCH, 2'b01, 32'h0000_DEAD);
        irq_i = 4'b0001;
        found = 0; saw_int = 0;
        for (int w = 0; w < 6 && found == 0; w++) begin
            cyc();
            if (int_o) saw_int = 1;
            if (!stall_o) found = 1;
        end
        chk("nomie_woke", 32'(found), 32'd1);
        chk("nomie_no_int", 32'(saw_int), 32'd0);
        rd(CSR_MSCRATCH, 32'd0, "sleep_ignores_csr");
        rd(CSR_MEPC, 32'h104, "nomie_mepc_kept");
        irq_i = 4'd0;
        cyc();

        // ---- reset while asleep
        csr_wr(CSR_MSTATUS, 2'b10, 32'h8);
        csr_en_i = 1'b1; wfi_i = 1'b1; pc_i = 32'h300;
        cyc(); idle();
        chk("rs_stall_before", stall_o, 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_no_int_in_reset", int_o, 32'd0);
        cyc();
        rst = 1'b0;
        chk("rs_stall_after", stall_o, 32'd0);
        chk("rs_int_after", int_o, 32'd0);
        rd(CSR_MSTATUS, 32'd0, "rs_mstatus");

        // ---- randomized CSR traffic against the model
        do_reset();
        mv = '{32'd0, 32'd0, 32'h0001_0000, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int k = 0; k < 60; k++) begin
            j  = $urandom_range(6, 0);
            op = 2'($urandom_range(3, 0));
            wd = ($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom);
            csr_en_i = 1'b1; csr_addr_i = ra[j]; csr_op_i = op; csr_wdata_i = wd;
            retire_i = 1'($urandom_range(1, 0));
            #1;
            chk("rand_rdata", csr_rdata_o, mv[j]);
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = mv[j] | wd;
                2'b11:   nv = mv[j] & ~wd;
                default: nv = mv[j];
            endcase
            if (op == 2'b01 || (op != 2'b00 && wd != 32'd0))
                mv[j] = (nv & mk[j]) | (mv[j] & ~mk[j]);
            cyc(); idle();
        end
        #1;
        chk("rand_no_stall", stall_o, 32'd0);
        rd(CSR_MINSTRET, 32'(retired), "rand_minstret");
        rd(CSR_MCYCLE, 32'(edges), "rand_mcycle");
        rd(CSR_MCYCLEH, 32'd0, "rand_mcycleh");
        rd(CSR_MINSTRETH, 32'd0, "rand_minstreth");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_irq_vec.md
# csr_irq_vec

Parametrised machine-mode CSR and interrupt unit for the CPU EX stage. It extends the single external-interrupt CSR block to NUM_IRQ local interrupt sources with per-source enables, fixed priority, an mcause/mscratch pair, a writable direct or vectored mtvec, and a two-state WFI sleep FSM. It sits beside the EX stage: it decodes CSR instructions, supplies trap and return PCs to IF, and stalls the pipeline during WFI.

## Interface
- NUM_IRQ, 4: number of local interrupt sources, 1..16; source i maps to mip/mie bit 16+i.
- CNT_BITS, 64: mcycle/minstret width, 33..64; the h-halves read bits CNT_BITS-1:32, zero-extended.
- MTVEC_RST, 32'h0001_0000: mtvec reset value.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- csr_en_i  in  1  EX holds a valid CSR/WFI/MRET instruction this cycle.
- csr_addr_i  in  12  CSR address.
- csr_op_i  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata_i  in  32  rs1 value or zimm.
- csr_rdata_o  out  32  old CSR value, combinational; 0 for unmapped addresses.
- pc_i  in  32  PC of the EX instruction.
- retire_i  in  1  instruction retires this cycle.
- wfi_i, mret_i  in  1  decoded WFI / MRET, qualified by csr_en_i.
- irq_i  in  NUM_IRQ  level-sensitive interrupt requests.
- trap_pc_o  out  32  trap target.
- ret_pc_o  out  32  equals mepc.
- int_o  out  1  interrupt taken this cycle (pulse).
- irq_id_o  out  4  winning source index.
- mret_o  out  1  equals csr_en_i & mret_i.
- stall_o  out  1  pipeline hold while asleep.

## Operation
- mip[16+i] is a register updated every cycle from irq_i[i]. It is read-only; writes are ignored.
- pend = mip & mie. irq_id_o is the lowest set index in pend; it is 0 when pend is empty.
- Take condition: take = mstatus.MIE & |pend & (state==SLEEP | csr_en_i). int_o = take.
- On take, registered at the next edge:
  - mepc <= pc_i in RUN, or the latched wfi_pc+4 in SLEEP.
  - mcause <= 32'h8000_0000 | (16+id).
  - MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
- trap_pc_o: mtvec.MODE=0 gives {mtvec[31:2],2'b00}. MODE=1 gives {mtvec[31:2],2'b00} + 4*(16+id), using 32-bit wrap-around.
- MRET (csr_en_i & mret_i, no take): MIE <= MPIE; MPIE <= 1; MPP <= 2'b11.
- CSR access (csr_en_i, op≠00, no take, no mret):
  - new = wdata, old|wdata, or old&~wdata for write, set and clear.
  - For set/clear with wdata==0, nothing is written.
  - Write masks:
    - mstatus: bits 3, 7 and 12:11 only.
    - mie: bits 16+NUM_IRQ-1:16 only.
    - mtvec: bit 1 reads 0.
    - mepc: bits 1:0 read 0.
    - mscratch and mcause: full 32 bits.
- Update priority per cycle: take > mret > CSR write.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when retire_i is high.
  - A CSR write to mcycle, mcycleh, minstret or minstreth replaces that half in that cycle; the increment is suppressed for the whole counter.
  - Counters wrap at 2^CNT_BITS.
- FSM state RUN:
  - csr_en_i & wfi_i & ~|pend → SLEEP; latch wfi_pc <= pc_i.
  - csr_en_i & wfi_i & |pend → WFI acts as a NOP.
- FSM state SLEEP:
  - stall_o=1; csr_en_i is ignored.
  - When |pend: take fires if MIE=1, and the FSM goes → RUN in either case.
  - With MIE=0, execution resumes after the WFI without a trap.
- Addresses are in the shared package: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82.

## Timing
- Reset values:
  - mstatus, mie, mip, mepc, mcause, mscratch and both counters are 0.
  - mtvec = MTVEC_RST.
  - State is RUN.
  - stall_o, int_o, mret_o and irq_id_o are 0.
  - trap_pc_o = MTVEC_RST, ret_pc_o = 0, csr_rdata_o = 0.
- irq_i reaches mip one cycle after it changes. int_o can assert at the earliest in the cycle after irq_i rises.
- csr_rdata_o, trap_pc_o, int_o and irq_id_o are combinational in the access cycle. Register effects are visible in the next cycle.
- stall_o is registered:
  - It goes to 1 the cycle after the WFI.
  - It goes to 0 in the cycle after pend becomes nonzero; take fires in that same wake cycle.
- A read-modify-write returns the pre-write value.
- rst asserted during SLEEP returns the FSM to RUN and stall_o to 0 on that edge.

## Structure
- Package csr_pkg holds:
  - CSR address constants and bit positions (MIE=3, MPIE=7, MPP=12:11, LOCAL_IRQ_BASE=16);
  - the csr_op_e enum {CSR_NONE, CSR_WR, CSR_SET, CSR_CLR};
  - the sleep_state_e enum {ST_RUN, ST_SLEEP}.
- One sub-module, csr_irq_arb: a parametrised fixed-priority encoder taking pend[NUM_IRQ-1:0] and producing valid and id[3:0].

## Test plan
- Reset: after rst, mtvec reads 32'h0001_0000, all other CSRs read 0, and stall_o=0.
- Set bit: write mstatus 0 then set 32'h8 → mstatus reads 32'h8. Clear with wdata=0 → value unchanged.
- Vectored priority: mtvec=32'h0002_0001, all mie bits set, MIE=1, irq_i=4'b0101 → int_o=1, irq_id_o=0, trap_pc_o=32'h0002_0040. Next cycle: mcause=32'h8000_0010, MIE=0, MPIE=1.
- WFI sleep: MIE=1, mie bit 18 set, WFI at pc 32'h100 → stall_o=1 the next cycle. Raise irq_i[2] → take fires, mepc=32'h104, stall_o drops. Then MRET → MIE=1, ret_pc_o=32'h104.
- Counter write: write mcycle=32'hFFFF_FFFF → next cycle mcycleh=0, and the following cycle mcycleh=1 (carry).
- Reset mid-sleep: assert rst while stall_o=1 → the next cycle shows stall_o=0 and state RUN, with no int_o pulse.
